// File: rtl/cache_port_arbiter.sv
// Round-robin two-requester front end for a single-port direct-mapped cache.
// One access in flight at a time, fixed miss-penalty stall, saturating hit/miss counters.
module cache_port_arbiter #(
   parameter int ADDR_W       = 32,
   parameter int DATA_W       = 32,
   parameter int MISS_PENALTY = 4,
   parameter int COUNT_W      = 16
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [1:0]          req_valid,
   output logic [1:0]          req_ready,
   input  logic [2*ADDR_W-1:0] req_addr,
   input  logic [1:0]          req_we,
   input  logic [2*DATA_W-1:0] req_wdata,
   output logic [1:0]          resp_valid,
   output logic [DATA_W-1:0]   resp_rdata,
   output logic                resp_hit,
   output logic                cache_valid,
   output logic [ADDR_W-1:0]   cache_address,
   output logic                cache_is_write,
   output logic [DATA_W-1:0]   cache_write_data,
   input  logic                cache_hit,
   input  logic [DATA_W-1:0]   cache_read_data,
   output logic [COUNT_W-1:0]  hit_count,
   output logic [COUNT_W-1:0]  miss_count
);
   localparam int PEN_W = (MISS_PENALTY > 1) ? $clog2(MISS_PENALTY + 1) : 1;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic              we;
      logic [DATA_W-1:0] wdata;
   } req_t;

   typedef enum logic [1:0] {IDLE, ACCESS, MISS_WAIT, RESP} state_t;

   state_t           state, state_nxt;
   req_t [1:0]       req;
   req_t             cur;
   logic             cur_id;
   logic             last_grant;
   logic             grant_id;
   logic             accept;
   logic [PEN_W-1:0] pen_cnt;

   for (genvar i = 0; i < 2; i++) begin : g_req
      assign req[i] = '{addr:  req_addr[i*ADDR_W +: ADDR_W],
                        we:    req_we[i],
                        wdata: req_wdata[i*DATA_W +: DATA_W]};
   end

   // Tie goes to whoever was not served last; a lone requester always wins.
   always_comb begin
      grant_id = req_valid[1];
      if (&req_valid) grant_id = ~last_grant;
   end

   assign accept    = (state == IDLE) && (|req_valid);
   assign req_ready = accept ? (grant_id ? 2'b10 : 2'b01) : 2'b00;

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:      if (accept) state_nxt = ACCESS;
         ACCESS:    state_nxt = (cache_hit || MISS_PENALTY == 0) ? RESP : MISS_WAIT;
         MISS_WAIT: if (pen_cnt <= PEN_W'(1)) state_nxt = RESP;
         RESP:      state_nxt = IDLE;
         default:   state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         cur        <= '0;
         cur_id     <= 1'b0;
         last_grant <= 1'b1;
         pen_cnt    <= '0;
         resp_rdata <= '0;
         resp_hit   <= 1'b0;
         hit_count  <= '0;
         miss_count <= '0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            cur        <= req[grant_id];
            cur_id     <= grant_id;
            last_grant <= grant_id;
         end
         if (state == ACCESS) begin
            resp_rdata <= cache_read_data;
            resp_hit   <= cache_hit;
            pen_cnt    <= PEN_W'(MISS_PENALTY);
            if (cache_hit) begin
               if (hit_count != '1) hit_count <= hit_count + 1'b1;
            end else begin
               if (miss_count != '1) miss_count <= miss_count + 1'b1;
            end
         end else if (state == MISS_WAIT) begin
            pen_cnt <= pen_cnt - 1'b1;
         end
      end
   end

   // Cache pins carry the latched request; they read as zero straight out of reset.
   assign cache_valid      = (state == ACCESS);
   assign cache_address    = cur.addr;
   assign cache_is_write   = cur.we;
   assign cache_write_data = cur.wdata;
   assign resp_valid       = (state == RESP) ? (cur_id ? 2'b10 : 2'b01) : 2'b00;

endmodule

// File: tb/tb_cache_port_arbiter.sv
// Randomized scoreboard bench for cache_port_arbiter with a behavioural direct-mapped cache.
module tb_cache_port_arbiter;
   localparam int PEN = 4;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   logic [1:0]  req_valid, req_ready, req_we, resp_valid;
   logic [63:0] req_addr, req_wdata;
   logic [31:0] resp_rdata, cache_address, cache_write_data;
   logic        resp_hit, cache_valid, cache_is_write;
   logic        cache_hit = 1'b0;
   logic [31:0] cache_read_data = 32'h0;
   logic [15:0] hit_count, miss_count;

   logic [1:0]  req_valid_z, req_ready_z, req_we_z, resp_valid_z;
   logic [63:0] req_addr_z, req_wdata_z;
   logic [31:0] resp_rdata_z, cache_address_z, cache_write_data_z, cache_read_data_z;
   logic        resp_hit_z, cache_valid_z, cache_is_write_z, cache_hit_z;
   logic [3:0]  hit_count_z, miss_count_z;

   cache_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MISS_PENALTY(PEN), .COUNT_W(16)) dut (
      .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_addr(req_addr), .req_we(req_we), .req_wdata(req_wdata), .resp_valid(resp_valid),
      .resp_rdata(resp_rdata), .resp_hit(resp_hit), .cache_valid(cache_valid),
      .cache_address(cache_address), .cache_is_write(cache_is_write),
      .cache_write_data(cache_write_data), .cache_hit(cache_hit),
      .cache_read_data(cache_read_data), .hit_count(hit_count), .miss_count(miss_count));

   cache_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MISS_PENALTY(0), .COUNT_W(4)) dut_z (
      .clk(clk), .reset_n(reset_n), .req_valid(req_valid_z), .req_ready(req_ready_z),
      .req_addr(req_addr_z), .req_we(req_we_z), .req_wdata(req_wdata_z), .resp_valid(resp_valid_z),
      .resp_rdata(resp_rdata_z), .resp_hit(resp_hit_z), .cache_valid(cache_valid_z),
      .cache_address(cache_address_z), .cache_is_write(cache_is_write_z),
      .cache_write_data(cache_write_data_z), .cache_hit(cache_hit_z),
      .cache_read_data(cache_read_data_z), .hit_count(hit_count_z), .miss_count(miss_count_z));

   // Second instance only ever sees cold misses.
   assign cache_hit_z       = 1'b0;
   assign cache_read_data_z = cache_address_z ^ 32'h1234_5678;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int          id;
      logic [31:0] addr;
      logic        we;
      logic [31:0] wdata;
      int          acc_cyc;
      logic        hit;
      logic [31:0] rdata;
      int          resp_cyc;
   } txn_t;

   txn_t exp_q[$];
   txn_t resp_q[$];
   int   grant_q[$];

   // Reference state: arbitration, counters and a write-allocate, read-no-allocate write-back cache.
   bit          ref_busy = 1'b0;
   bit          ref_last = 1'b1;
   int          ref_hits = 0, ref_misses = 0;
   int          accept_cnt = 0, resp_cnt = 0;
   int          last_lat = 0, last_acc = 0;
   logic        last_hit = 1'b0;
   logic [31:0] last_rdata = 32'h0;
   bit          line_v [1024];
   logic [19:0] line_tag [1024];
   logic [31:0] line_data [1024];
   logic [31:0] mem [logic [31:0]];

   function automatic logic [31:0] mem_rd(input logic [31:0] a);
      if (mem.exists(a)) return mem[a];
      return a ^ 32'hDEAD_BEEF;
   endfunction

   txn_t        t_m;
   logic [1:0]  exp_rdy;
   logic [9:0]  midx;
   logic        mhit;
   logic [31:0] mrd;

   always @(negedge clk) begin
      if (!reset_n) begin
         exp_q.delete();
         resp_q.delete();
         ref_busy   = 1'b0;
         ref_last   = 1'b1;
         ref_hits   = 0;
         ref_misses = 0;
      end else begin
         exp_rdy = 2'b00;
         if (!ref_busy && req_valid != 2'b00)
            exp_rdy = (req_valid == 2'b11) ? (ref_last ? 2'b01 : 2'b10) : req_valid;
         check("req_ready", req_ready, exp_rdy);
         if (exp_rdy != 2'b00 && req_ready == exp_rdy) begin
            t_m.id      = exp_rdy[1] ? 1 : 0;
            t_m.addr    = req_addr[t_m.id*32 +: 32];
            t_m.we      = req_we[t_m.id];
            t_m.wdata   = req_wdata[t_m.id*32 +: 32];
            t_m.acc_cyc = cyc + 1;
            exp_q.push_back(t_m);
            grant_q.push_back(t_m.id);
            ref_busy = 1'b1;
            ref_last = exp_rdy[1];
            last_acc = t_m.acc_cyc;
            accept_cnt++;
         end

         if (cache_valid) begin
            if (exp_q.size() == 0) check("unexpected_access", 1, 0);
            else begin
               t_m = exp_q.pop_front();
               check("access_cycle", cyc, t_m.acc_cyc);
               check("cache_address", cache_address, t_m.addr);
               check("cache_is_write", cache_is_write, t_m.we);
               if (t_m.we) check("cache_write_data", cache_write_data, t_m.wdata);
               midx = t_m.addr[11:2];
               mhit = line_v[midx] && line_tag[midx] == t_m.addr[31:12];
               mrd  = mhit ? line_data[midx] : mem_rd(t_m.addr);
               cache_hit       = mhit;
               cache_read_data = mrd;
               if (t_m.we) begin
                  if (!mhit && line_v[midx]) mem[{line_tag[midx], midx, 2'b00}] = line_data[midx];
                  line_v[midx]    = 1'b1;
                  line_tag[midx]  = t_m.addr[31:12];
                  line_data[midx] = t_m.wdata;
               end
               if (mhit) begin if (ref_hits < 65535) ref_hits++; end
               else begin if (ref_misses < 65535) ref_misses++; end
               t_m.hit      = mhit;
               t_m.rdata    = mrd;
               t_m.resp_cyc = cyc + 1 + (mhit ? 0 : PEN);
               resp_q.push_back(t_m);
            end
         end else if (exp_q.size() != 0 && cyc > exp_q[0].acc_cyc) begin
            check("access_timeout", 0, 1);
            void'(exp_q.pop_front());
            ref_busy = 1'b0;
         end

         if (resp_valid != 2'b00) begin
            resp_cnt++;
            if (resp_q.size() == 0) check("unexpected_resp", resp_valid, 0);
            else begin
               t_m = resp_q.pop_front();
               check("resp_valid", resp_valid, (t_m.id == 1) ? 2'b10 : 2'b01);
               check("resp_cycle", cyc, t_m.resp_cyc);
               check("resp_hit", resp_hit, t_m.hit);
               check("resp_rdata", resp_rdata, t_m.rdata);
               check("hit_count", hit_count, ref_hits);
               check("miss_count", miss_count, ref_misses);
               last_hit   = resp_hit;
               last_rdata = resp_rdata;
               last_lat   = cyc - t_m.acc_cyc;
            end
            ref_busy = 1'b0;
         end else if (resp_q.size() != 0 && cyc > resp_q[0].resp_cyc) begin
            check("resp_timeout", 0, 1);
            void'(resp_q.pop_front());
            ref_busy = 1'b0;
         end
      end
   end

   task automatic set_req(input int i, input logic [31:0] a, input logic w, input logic [31:0] d);
      req_addr[i*32 +: 32]  = a;
      req_we[i]             = w;
      req_wdata[i*32 +: 32] = d;
      req_valid[i]          = 1'b1;
   endtask

   task automatic rand_req(input int i);
      logic [31:0] a;
      a = (32'($urandom_range(0, 2)) << 28) | (32'($urandom_range(1, 7)) << 2);
      set_req(i, a, 1'($urandom_range(0, 1)), $urandom);
   endtask

   // mode 0: no new requests, 1: random arrivals, 2: both requesters always pending.
   task automatic drive_txns(input int n, input int mode);
      int target, seen, g;
      target = accept_cnt + n;
      seen   = accept_cnt;
      g      = 0;
      while (accept_cnt < target && g < 3000) begin
         @(posedge clk); #1;
         g++;
         if (accept_cnt != seen) begin
            req_valid[grant_q[grant_q.size()-1]] = 1'b0;
            seen = accept_cnt;
         end
         if (accept_cnt < target && mode != 0)
            for (int i = 0; i < 2; i++)
               if (!req_valid[i] && (mode == 2 || $urandom_range(0, 2) == 0)) rand_req(i);
      end
      if (g >= 3000) check("drive_timeout", 0, 1);
      req_valid = 2'b00;
   endtask

   task automatic wait_quiet();
      int g;
      g = 0;
      while ((ref_busy || exp_q.size() != 0 || resp_q.size() != 0) && g < 200) begin
         @(posedge clk); #1;
         g++;
      end
      if (g >= 200) check("quiet_timeout", 0, 1);
      @(posedge clk); #1;
   endtask

   task automatic issue(input int i, input logic [31:0] a, input logic w, input logic [31:0] d);
      set_req(i, a, w, d);
      drive_txns(1, 0);
      wait_quiet();
   endtask

   initial begin
      #500_000;
      $display("FAIL watchdog: simulation did not finish, %0d checks", checks);
      $fatal(1);
   end

   initial begin
      int rel, base, rc;
      req_valid = 2'b00; req_addr = '0; req_we = 2'b00; req_wdata = '0;
      req_valid_z = 2'b00; req_addr_z = '0; req_we_z = 2'b00; req_wdata_z = '0;

      #12;
      check("rst_req_ready", req_ready, 0);
      check("rst_resp_valid", resp_valid, 0);
      check("rst_resp_rdata", resp_rdata, 0);
      check("rst_resp_hit", resp_hit, 0);
      check("rst_cache_valid", cache_valid, 0);
      check("rst_cache_address", cache_address, 0);
      check("rst_cache_is_write", cache_is_write, 0);
      check("rst_cache_write_data", cache_write_data, 0);
      check("rst_hit_count", hit_count, 0);
      check("rst_miss_count", miss_count, 0);

      @(posedge clk); #1;
      reset_n = 1'b1;
      rel = cyc;

      // Cold write miss from requester 0.
      issue(0, 32'h0000_1000, 1'b1, 32'hAAAA_0000);
      check("cold_first_cycle_grant", last_acc, rel + 1);
      check("cold_hit", last_hit, 0);
      check("cold_latency", last_lat, 5);
      check("cold_miss_count", miss_count, 1);

      // Read hit from requester 1.
      issue(1, 32'h0000_1000, 1'b0, 32'h0);
      check("hit_flag", last_hit, 1);
      check("hit_rdata", last_rdata, 32'hAAAA_0000);
      check("hit_latency", last_lat, 1);
      check("hit_count_1", hit_count, 1);

      // Both requesters continuously pending.
      base = grant_q.size();
      drive_txns(4, 2);
      wait_quiet();
      for (int j = 0; j < 4; j++) check($sformatf("rr_grant_%0d", j), grant_q[base+j], j % 2);

      // Same index, different tag.
      issue(0, 32'h1000_1000, 1'b1, 32'hBBBB_0000);
      check("evict_write_hit", last_hit, 0);
      issue(1, 32'h0000_1000, 1'b0, 32'h0);
      check("evict_read_hit", last_hit, 0);
      check("evict_read_rdata", last_rdata, 32'hAAAA_0000);
      issue(0, 32'h1000_1000, 1'b0, 32'h0);
      check("new_line_hit", last_hit, 1);
      check("new_line_rdata", last_rdata, 32'hBBBB_0000);

      drive_txns(40, 1);
      wait_quiet();

      // Reset during the miss stall.
      set_req(0, 32'h3000_0004, 1'b0, 32'h0);
      drive_txns(1, 0);
      @(negedge clk);
      @(negedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      check("midrst_resp_valid", resp_valid, 0);
      check("midrst_resp_rdata", resp_rdata, 0);
      check("midrst_cache_valid", cache_valid, 0);
      check("midrst_cache_address", cache_address, 0);
      check("midrst_hit_count", hit_count, 0);
      check("midrst_miss_count", miss_count, 0);
      rc = resp_cnt;
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;
      repeat (12) @(posedge clk);
      #1;
      check("midrst_no_resp", resp_cnt, rc);
      base = grant_q.size();
      drive_txns(1, 2);
      wait_quiet();
      check("midrst_first_tie", grant_q[base], 0);

      // No-penalty instance with 4-bit counters.
      for (int i = 0; i < 20; i++) begin
         logic [31:0] a;
         int g;
         a = 32'h4000_0000 | (32'(i) << 4);
         req_addr_z[31:0] = a;
         req_we_z         = 2'b00;
         req_valid_z      = 2'b01;
         g = 0;
         do begin @(negedge clk); g++; end while (req_ready_z != 2'b01 && g < 20);
         check("z_ready", req_ready_z, 2'b01);
         @(posedge clk); #1;
         req_valid_z = 2'b00;
         @(negedge clk);
         check("z_access", cache_valid_z, 1);
         check("z_address", cache_address_z, a);
         @(negedge clk);
         check("z_access_one_cycle", cache_valid_z, 0);
         check("z_resp_valid", resp_valid_z, 2'b01);
         check("z_resp_rdata", resp_rdata_z, a ^ 32'h1234_5678);
         check("z_resp_hit", resp_hit_z, 0);
         check("z_miss_count", miss_count_z, (i + 1 > 15) ? 15 : i + 1);
      end
      check("z_hit_count", hit_count_z, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
